// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel-tick divider, h/v position counters, registered active-low syncs.
// Optional frame_tick output is built only when VGA_SYNC_FRAME_TICK_EN is defined.
module vga_sync_gen #(
  parameter int unsigned HD      = 640,
  parameter int unsigned HF      = 16,
  parameter int unsigned HR      = 96,
  parameter int unsigned HB      = 48,
  parameter int unsigned VD      = 480,
  parameter int unsigned VF      = 10,
  parameter int unsigned VR      = 2,
  parameter int unsigned VB      = 33,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
`ifdef VGA_SYNC_FRAME_TICK_EN
  output logic       frame_tick,
`endif
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y
);

  localparam int unsigned HTot = HD + HF + HR + HB;
  localparam int unsigned VTot = VD + VF + VR + VB;

  localparam logic [9:0] HLast      = 10'(HTot - 1);
  localparam logic [9:0] VLast      = 10'(VTot - 1);
  localparam logic [9:0] HDisp      = 10'(HD);
  localparam logic [9:0] VDisp      = 10'(VD);
  localparam logic [9:0] HSyncStart = 10'(HD + HF);
  localparam logic [9:0] HSyncEnd   = 10'(HD + HF + HR - 1);
  localparam logic [9:0] VSyncStart = 10'(VD + VF);
  localparam logic [9:0] VSyncEnd   = 10'(VD + VF + VR - 1);

  logic       tick;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       h_wrap;
  logic       hsync_q, vsync_q;

  // Pixel-rate divider; with CLK_DIV == 1 every clk is a pixel.
  if (CLK_DIV > 1) begin : g_div
    localparam int unsigned   DivW    = $clog2(CLK_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        div_q <= '0;
      end else if (div_q == DivLast) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + DivW'(1);
      end
    end

    assign tick = (div_q == DivLast);
  end else begin : g_nodiv
    assign tick = 1'b1;
  end

  always_comb begin
    h_wrap = tick && (h_q == HLast);
    h_d    = h_q;
    v_d    = v_q;
    if (tick) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;
    end
    if (h_wrap) begin
      v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
    end
  end

  // Syncs decode the next-count value so they change on the same edge as pix_x/pix_y.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q     <= 10'd0;
      v_q     <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= !((h_d >= HSyncStart) && (h_d <= HSyncEnd));
      vsync_q <= !((v_d >= VSyncStart) && (v_d <= VSyncEnd));
    end
  end

`ifdef VGA_SYNC_FRAME_TICK_EN
  logic frame_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= 1'b0;
    end else begin
      frame_q <= h_wrap && (v_q == VLast);
    end
  end

  assign frame_tick = frame_q;
`endif

  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign p_tick   = tick;
  assign pix_x    = h_q;
  assign pix_y    = v_q;
  assign video_on = (h_q < HDisp) && (v_q < VDisp);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 timing, a shrunken-frame instance for
// whole-frame and wrap checks, and a CLK_DIV=1 instance.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic       a_hsync, a_vsync, a_von, a_pt;
  logic [9:0] a_x, a_y;
  logic       b_hsync, b_vsync, b_von, b_pt;
  logic [9:0] b_x, b_y;
  logic       c_hsync, c_vsync, c_von, c_pt;
  logic [9:0] c_x, c_y;
`ifdef VGA_SYNC_FRAME_TICK_EN
  logic       a_ft, b_ft, c_ft;
`endif

  vga_sync_gen u_a (
    .clk       (clk),
    .reset     (reset),
`ifdef VGA_SYNC_FRAME_TICK_EN
    .frame_tick(a_ft),
`endif
    .hsync     (a_hsync),
    .vsync     (a_vsync),
    .video_on  (a_von),
    .p_tick    (a_pt),
    .pix_x     (a_x),
    .pix_y     (a_y)
  );

  // Small frame: H_TOT=25 (hsync low 18..21), V_TOT=15 (vsync low 10..11), 750 clks/frame.
  vga_sync_gen #(
    .HD(16), .HF(2), .HR(4), .HB(3), .VD(8), .VF(2), .VR(2), .VB(3), .CLK_DIV(2)
  ) u_b (
    .clk       (clk),
    .reset     (reset),
`ifdef VGA_SYNC_FRAME_TICK_EN
    .frame_tick(b_ft),
`endif
    .hsync     (b_hsync),
    .vsync     (b_vsync),
    .video_on  (b_von),
    .p_tick    (b_pt),
    .pix_x     (b_x),
    .pix_y     (b_y)
  );

  vga_sync_gen #(
    .CLK_DIV(1)
  ) u_c (
    .clk       (clk),
    .reset     (reset),
`ifdef VGA_SYNC_FRAME_TICK_EN
    .frame_tick(c_ft),
`endif
    .hsync     (c_hsync),
    .vsync     (c_vsync),
    .video_on  (c_von),
    .p_tick    (c_pt),
    .pix_x     (c_x),
    .pix_y     (c_y)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected state n clks after reset release, derived from the timing geometry.
  task automatic check_dut(input string nm, input int n, input int div,
                           input int hd, input int hf, input int hr, input int hb,
                           input int vd, input int vf, input int vr, input int vb,
                           input logic [9:0] x, input logic [9:0] y, input logic hs,
                           input logic vs, input logic von, input logic pt);
    int htot, vtot, k, ex, ey;
    logic ehs, evs, evon, ept;
    htot = hd + hf + hr + hb;
    vtot = vd + vf + vr + vb;
    k    = n / div;
    ex   = k % htot;
    ey   = (k / htot) % vtot;
    ehs  = !(ex >= hd + hf && ex <= hd + hf + hr - 1);
    evs  = !(ey >= vd + vf && ey <= vd + vf + vr - 1);
    evon = (ex < hd) && (ey < vd);
    ept  = (div == 1) ? 1'b1 : ((n % div) == div - 1);
    check({nm, ".pix_x"},    32'(x),   32'(ex));
    check({nm, ".pix_y"},    32'(y),   32'(ey));
    check({nm, ".hsync"},    32'(hs),  32'(ehs));
    check({nm, ".vsync"},    32'(vs),  32'(evs));
    check({nm, ".video_on"}, 32'(von), 32'(evon));
    check({nm, ".p_tick"},   32'(pt),  32'(ept));
  endtask

  task automatic check_all(input int n);
    check_dut("a", n, 2, 640, 16, 96, 48, 480, 10, 2, 33, a_x, a_y, a_hsync, a_vsync, a_von,
              a_pt);
    check_dut("b", n, 2, 16, 2, 4, 3, 8, 2, 2, 3, b_x, b_y, b_hsync, b_vsync, b_von, b_pt);
    check_dut("c", n, 1, 640, 16, 96, 48, 480, 10, 2, 33, c_x, c_y, c_hsync, c_vsync, c_von,
              c_pt);
`ifdef VGA_SYNC_FRAME_TICK_EN
    check("a.frame_tick", 32'(a_ft), 32'd0);
    check("b.frame_tick", 32'(b_ft), 32'((n > 0) && (n % 750 == 0)));
    check("c.frame_tick", 32'(c_ft), 32'd0);
`endif
  endtask

  int a_hs_low, a_hs_first, b_vs_low, b_von_cnt, c_ticks, b_ft_cnt;

  initial begin
    a_hs_low   = 0;
    a_hs_first = -1;
    b_vs_low   = 0;
    b_von_cnt  = 0;
    c_ticks    = 0;
    b_ft_cnt   = 0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.pix_x",  32'(a_x),     32'd0);
    check("rst.pix_y",  32'(a_y),     32'd0);
    check("rst.hsync",  32'(a_hsync), 32'd1);
    check("rst.vsync",  32'(a_vsync), 32'd1);
    check("rst.p_tick", 32'(a_pt),    32'd0);
`ifdef VGA_SYNC_FRAME_TICK_EN
    check("rst.frame_tick", 32'(b_ft), 32'd0);
`endif

    reset = 1'b0;
    check_all(0);
    check("rel.video_on", 32'(a_von), 32'd1);
    for (int i = 1; i <= 1700; i++) begin
      @(negedge clk);
      check_all(i);
      if (i <= 1599 && a_pt) begin
        if (!a_hsync) begin
          a_hs_low++;
          if (a_hs_first < 0) a_hs_first = int'(a_x);
        end
      end
      if (i <= 749 && b_pt) begin
        if (!b_vsync) b_vs_low++;
        if (b_von) b_von_cnt++;
      end
      if (i <= 800 && c_pt) c_ticks++;
`ifdef VGA_SYNC_FRAME_TICK_EN
      if (b_ft) b_ft_cnt++;
`endif
      if (i == 1)    check("first_tick", 32'(a_pt), 32'd1);
      if (i == 749)  check("b.pre_wrap", 32'({b_x, b_y}), 32'({10'd24, 10'd14}));
      if (i == 750)  check("b.wrap",     32'({b_x, b_y}), 32'd0);
      if (i == 800)  check("c.h_period", 32'(c_x), 32'd0);
      if (i == 1600) check("a.line_wrap", 32'({a_x, a_y}), 32'({10'd0, 10'd1}));
    end
    check("a.hsync_low_ticks", 32'(a_hs_low),   32'd96);
    check("a.hsync_first_x",   32'(a_hs_first), 32'd656);
    check("b.vsync_low_ticks", 32'(b_vs_low),   32'd50);
    check("b.video_on_ticks",  32'(b_von_cnt),  32'd128);
    check("c.ticks_per_line",  32'(c_ticks),    32'd800);
`ifdef VGA_SYNC_FRAME_TICK_EN
    check("b.frame_tick_count", 32'(b_ft_cnt), 32'd2);
`endif

    // Mid-frame reset while both syncs are active on the small instance.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 590; i++) begin
      @(negedge clk);
      check_all(i);
    end
    check("mid.pre_hsync", 32'(b_hsync), 32'd0);
    check("mid.pre_vsync", 32'(b_vsync), 32'd0);
    check("mid.pre_pos",   32'({b_x, b_y}), 32'({10'd20, 10'd11}));
    reset = 1'b1;
    @(negedge clk);
    check("mid.pix_x",  32'(b_x),     32'd0);
    check("mid.pix_y",  32'(b_y),     32'd0);
    check("mid.hsync",  32'(b_hsync), 32'd1);
    check("mid.vsync",  32'(b_vsync), 32'd1);
    check("mid.p_tick", 32'(b_pt),    32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      check_all(i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
